// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {DB5 = 2'd0, DB6 = 2'd1, DB7 = 2'd2, DB8 = 2'd3} data_bits_e;
  typedef enum logic {RTS_RECV = 1'b0, RTS_STOP = 1'b1} rts_state_e;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_RTS_HI = 12;
  localparam int DEF_RTS_LO = 4;

  // Zero the bits above the configured character length.
  function automatic logic [7:0] mask_char(input logic [7:0] d, input data_bits_e db);
    case (db)
      DB5:     return {3'b000, d[4:0]};
      DB6:     return {2'b00, d[5:0]};
      DB7:     return {1'b0, d[6:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO: storage, pointers and occupancy.
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with character masking, sticky overflow and RTS hysteresis.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RTS_HI = DEF_RTS_HI,
  parameter int RTS_LO = DEF_RTS_LO
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  input  logic                     parity_error,
  input  logic [1:0]               data_bit_num,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [7:0]               rd_data,
  output logic                     rd_perr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rts_n,
  output logic                     overflow,
  input  logic                     clear_ovf
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push, pop, drop, full, empty;
  logic [8:0]    wdata, rdata;
  logic [CW-1:0] cnt_nxt;
  logic          ovf_q, ovf_d;
  rts_state_e    rts_q, rts_d;

  assign rd_valid = !empty && !reset;
  assign pop      = rd_valid && rd_ready;
  assign push     = rx_done && (!full || pop);
  assign drop     = rx_done && !push;
  assign wdata    = {parity_error, mask_char(rx_data, data_bits_e'(data_bit_num))};

  uart_sync_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rd_data = rd_valid ? rdata[7:0] : 8'h00;
  assign rd_perr = rd_valid ? rdata[8]   : 1'b0;

  // A new drop outranks a coincident clear.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;

  // Thresholds are judged on the occupancy the FIFO will hold after this edge.
  assign cnt_nxt = count + CW'(push) - CW'(pop);

  always_comb begin
    rts_d = rts_q;
    case (rts_q)
      RTS_RECV: if (cnt_nxt >= CW'(RTS_HI)) rts_d = RTS_STOP;
      RTS_STOP: if (cnt_nxt <= CW'(RTS_LO)) rts_d = RTS_RECV;
      default:  rts_d = RTS_RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) rts_q <= RTS_RECV;
    else       rts_q <= rts_d;
  end

  assign rts_n = (rts_q == RTS_STOP);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue-based reference model.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       reset, rx_done, parity_error, rd_ready, clear_ovf;
  logic [7:0] rx_data;
  logic [1:0] data_bit_num;
  logic       rd_valid, rd_perr, rts_n, overflow;
  logic [7:0] rd_data;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  logic [8:0] mq[$];
  bit         m_ovf, m_rts;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .RTS_HI(12), .RTS_LO(4)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .parity_error(parity_error), .data_bit_num(data_bit_num),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_perr(rd_perr), .count(count), .rts_n(rts_n),
    .overflow(overflow), .clear_ovf(clear_ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the current inputs, then compare.
  task automatic tick();
    bit         mpop, mpush, mdrop, ev;
    logic [7:0] md;
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_rts = 1'b0;
    end else begin
      mpop  = (mq.size() > 0) && rd_ready;
      mpush = rx_done && ((mq.size() < 16) || mpop);
      mdrop = rx_done && !mpush;
      md    = rx_data & 8'((1 << (5 + int'(data_bit_num))) - 1);
      if (mpop)  void'(mq.pop_front());
      if (mpush) mq.push_back({parity_error, md});
      if (mdrop)          m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
      if (!m_rts && mq.size() >= 12)     m_rts = 1'b1;
      else if (m_rts && mq.size() <= 4)  m_rts = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    ev = !reset && (mq.size() > 0);
    chk("rd_valid", int'(rd_valid), int'(ev));
    chk("rd_data",  int'(rd_data),  ev ? int'(mq[0][7:0]) : 0);
    chk("rd_perr",  int'(rd_perr),  ev ? int'(mq[0][8]) : 0);
    chk("count",    int'(count),    mq.size());
    chk("rts_n",    int'(rts_n),    int'(m_rts));
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic push(input logic [7:0] d, input logic pe);
    rx_data = d; parity_error = pe; rx_done = 1'b1;
    tick();
    rx_done = 1'b0; parity_error = 1'b0;
  endtask

  task automatic pop1();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_done = 1'b0; parity_error = 1'b0; rd_ready = 1'b0;
    clear_ovf = 1'b0; rx_data = 8'h00; data_bit_num = 2'd3;
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_count", int'(count), 0);
    chk("reset_valid", int'(rd_valid), 0);
    chk("reset_rts", int'(rts_n), 0);
    chk("reset_ovf", int'(overflow), 0);

    // 8-bit character, held while not read
    push(8'hA5, 1'b0);
    chk("a5_valid", int'(rd_valid), 1);
    chk("a5_data", int'(rd_data), 'hA5);
    chk("a5_count", int'(count), 1);
    repeat (5) tick();
    chk("a5_hold", int'(rd_data), 'hA5);
    pop1();

    // 5-bit masking with parity flag
    data_bit_num = 2'd0;
    push(8'hFF, 1'b1);
    chk("db5_data", int'(rd_data), 'h1F);
    chk("db5_perr", int'(rd_perr), 1);
    pop1();

    // Length is captured at push time only
    data_bit_num = 2'd3;
    push(8'hFF, 1'b0);
    data_bit_num = 2'd0;
    tick();
    chk("db_sample", int'(rd_data), 'hFF);
    data_bit_num = 2'd3;
    pop1();

    // Empty reads do nothing
    rd_ready = 1'b1;
    repeat (3) tick();
    rd_ready = 1'b0;
    chk("empty_rd_count", int'(count), 0);

    // Fill, RTS, overflow
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b0);
      if (i == 10) chk("rts_below_hi", int'(rts_n), 0);
      if (i == 11) chk("rts_at_hi", int'(rts_n), 1);
    end
    chk("full_count", int'(count), 16);
    push(8'h55, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_head", int'(rd_data), 'h00);
    rx_data = 8'h66; rx_done = 1'b1; clear_ovf = 1'b1;
    tick();
    rx_done = 1'b0; clear_ovf = 1'b0;
    chk("ovf_set_wins", int'(overflow), 1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("ovf_clear", int'(overflow), 0);

    // Full with simultaneous push and pop
    rx_data = 8'h77; rx_done = 1'b1; rd_ready = 1'b1;
    tick();
    rx_done = 1'b0;
    chk("full_pp_count", int'(count), 16);
    chk("full_pp_ovf", int'(overflow), 0);
    chk("full_pp_head", int'(rd_data), 'h01);
    repeat (18) tick();
    rd_ready = 1'b0;
    chk("drain_valid", int'(rd_valid), 0);
    chk("drain_rts", int'(rts_n), 0);

    // Streaming through pointer wrap
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx_data = 8'(8'h80 + i); rx_done = 1'b1;
      tick();
    end
    rx_done = 1'b0;
    repeat (2) tick();
    rd_ready = 1'b0;
    chk("stream_count", int'(count), 0);

    // Reset mid-operation
    for (int i = 0; i < 7; i++) push(8'(8'h20 + i), 1'b0);
    chk("pre_rst_count", int'(count), 7);
    reset = 1'b1; rx_done = 1'b1; rd_ready = 1'b1; rx_data = 8'h99;
    tick();
    reset = 1'b0; rx_done = 1'b0; rd_ready = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_rts", int'(rts_n), 0);
    push(8'h3C, 1'b0);
    chk("post_rst_data", int'(rd_data), 'h3C);
    chk("post_rst_count", int'(count), 1);
    pop1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
